// File: rtl/ring_uart_tx.sv
// ring_uart_tx: drains a RingBuffer one byte at a time and serializes each
// byte as an 8N1 UART frame on txd (Phaethon debug/console output path).
//
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous reset, active-high
//   enable       permits new reads; a frame already in flight always completes
//   readEnable   one-cycle read request to the RingBuffer
//   dataReadAck  RingBuffer read success, valid the cycle after readEnable
//   dataRead     RingBuffer read data, valid with dataReadAck
//   txd          serial line, idle high
//   busy         high whenever the transmitter is not idle
//   frameCount   number of completed frames, wraps silently
module ring_uart_tx #(
   parameter int unsigned DATA_WIDTH   = 8,
   parameter int unsigned CLKS_PER_BIT = 16,
   parameter int unsigned COUNT_WIDTH  = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   enable,
   output logic                   readEnable,
   input  logic                   dataReadAck,
   input  logic [DATA_WIDTH-1:0]  dataRead,
   output logic                   txd,
   output logic                   busy,
   output logic [COUNT_WIDTH-1:0] frameCount
);

   localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int unsigned IDX_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DATA_WIDTH - 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      REQ   = 3'd1,
      ACK   = 3'd2,
      START = 3'd3,
      DATA  = 3'd4,
      STOP  = 3'd5
   } state_e;

   state_e                 state_q, state_d;
   logic [BAUD_W-1:0]      baud_q, baud_d;
   logic [IDX_W-1:0]       idx_q, idx_d;
   logic [DATA_WIDTH-1:0]  shift_q, shift_d;
   logic                   txd_q, txd_d;
   logic                   read_en_q, read_en_d;
   logic                   busy_q, busy_d;
   logic [COUNT_WIDTH-1:0] frame_cnt_q, frame_cnt_d;
   logic                   baud_last;

   // Next-state and registered-output computation
   always_comb begin
      state_d     = state_q;
      baud_d      = baud_q;
      idx_d       = idx_q;
      shift_d     = shift_q;
      txd_d       = txd_q;
      frame_cnt_d = frame_cnt_q;
      baud_last   = (baud_q == BAUD_LAST);

      unique case (state_q)
         IDLE: begin
            txd_d = 1'b1;
            if (enable) begin
               state_d = REQ;
            end
         end

         REQ: begin
            txd_d   = 1'b1;
            state_d = ACK;
         end

         // The byte is already popped once acked, so it is sent regardless of enable
         ACK: begin
            txd_d = 1'b1;
            if (dataReadAck) begin
               shift_d = dataRead;
               baud_d  = '0;
               txd_d   = 1'b0;
               state_d = START;
            end else begin
               state_d = IDLE;
            end
         end

         START: begin
            if (baud_last) begin
               baud_d  = '0;
               idx_d   = '0;
               txd_d   = shift_q[0];
               state_d = DATA;
            end else begin
               baud_d = baud_q + BAUD_W'(1);
            end
         end

         // LSB first: shift right and present the new bit 0 at each bit boundary
         DATA: begin
            if (baud_last) begin
               baud_d = '0;
               if (idx_q == IDX_LAST) begin
                  txd_d   = 1'b1;
                  state_d = STOP;
               end else begin
                  idx_d   = idx_q + IDX_W'(1);
                  shift_d = shift_q >> 1;
                  txd_d   = shift_d[0];
               end
            end else begin
               baud_d = baud_q + BAUD_W'(1);
            end
         end

         STOP: begin
            txd_d = 1'b1;
            if (baud_last) begin
               baud_d      = '0;
               frame_cnt_d = frame_cnt_q + COUNT_WIDTH'(1);
               state_d     = enable ? REQ : IDLE;
            end else begin
               baud_d = baud_q + BAUD_W'(1);
            end
         end

         default: begin
            txd_d   = 1'b1;
            baud_d  = '0;
            state_d = IDLE;
         end
      endcase

      // Outputs follow the state being entered so they change on the same edge
      read_en_d = (state_d == REQ);
      busy_d    = (state_d != IDLE);
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         baud_q      <= '0;
         idx_q       <= '0;
         shift_q     <= '0;
         txd_q       <= 1'b1;
         read_en_q   <= 1'b0;
         busy_q      <= 1'b0;
         frame_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         baud_q      <= baud_d;
         idx_q       <= idx_d;
         shift_q     <= shift_d;
         txd_q       <= txd_d;
         read_en_q   <= read_en_d;
         busy_q      <= busy_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end

   assign readEnable = read_en_q;
   assign txd        = txd_q;
   assign busy       = busy_q;
   assign frameCount = frame_cnt_q;

endmodule
